// File: rtl/pipeline_hazard_ctrl.sv
// Stall/flush sequencer for the five-stage pipeline registers.
// Covers boot flush, data-memory waits, taken branches and load-use hazards, plus saturating perf counters.
module pipeline_hazard_ctrl #(
  parameter int BOOT_CYCLES = 4,
  parameter int MEM_TIMEOUT = 255,
  parameter int CNT_W       = 32
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [4:0]       Rs1D,
  input  logic [4:0]       Rs2D,
  input  logic [4:0]       RdE,
  input  logic             LoadE,
  input  logic             RegWriteE,
  input  logic             PCSrcE,
  input  logic             MemReqM,
  input  logic             MemReadyM,
  output logic             StallF,
  output logic             StallD,
  output logic             FlushD,
  output logic             StallE,
  output logic             FlushE,
  output logic             StallM,
  output logic             FlushW,
  output logic             mem_timeout,
  output logic [CNT_W-1:0] stall_cycles,
  output logic [CNT_W-1:0] flush_events,
  output logic [1:0]       state
);

  localparam logic [1:0] ST_BOOT     = 2'd0;
  localparam logic [1:0] ST_RUN      = 2'd1;
  localparam logic [1:0] ST_MEM_WAIT = 2'd2;

  localparam int BW = (BOOT_CYCLES > 1) ? $clog2(BOOT_CYCLES) : 1;
  localparam int WW = $clog2(MEM_TIMEOUT + 1);
  localparam logic [BW-1:0]    BOOT_LAST = BW'(BOOT_CYCLES - 1);
  localparam logic [WW-1:0]    WAIT_MAX  = WW'(MEM_TIMEOUT);
  localparam logic [CNT_W-1:0] CNT_MAX   = '1;

  logic [1:0]       state_reg, state_next;
  logic [BW-1:0]    boot_cnt_reg, boot_cnt_next;
  logic [WW-1:0]    wait_cnt_reg, wait_cnt_next;
  logic             mem_timeout_reg, mem_timeout_next;
  logic [CNT_W-1:0] stall_cycles_reg, stall_cycles_next;
  logic [CNT_W-1:0] flush_events_reg, flush_events_next;

  logic memwait;
  logic load_use;

  assign memwait  = MemReqM & ~MemReadyM;
  assign load_use = LoadE & RegWriteE & (RdE != 5'd0) & ((RdE == Rs1D) | (RdE == Rs2D));

  always_comb begin
    StallF            = 1'b0;
    StallD            = 1'b0;
    FlushD            = 1'b0;
    StallE            = 1'b0;
    FlushE            = 1'b0;
    StallM            = 1'b0;
    FlushW            = 1'b0;
    state_next        = state_reg;
    boot_cnt_next     = boot_cnt_reg;
    wait_cnt_next     = wait_cnt_reg;
    mem_timeout_next  = mem_timeout_reg;
    stall_cycles_next = stall_cycles_reg;
    flush_events_next = flush_events_reg;

    case (state_reg)
      ST_BOOT: begin
        StallF        = 1'b1;
        FlushD        = 1'b1;
        FlushE        = 1'b1;
        boot_cnt_next = boot_cnt_reg + 1'b1;
        if (boot_cnt_reg == BOOT_LAST) begin
          state_next    = ST_RUN;
          boot_cnt_next = '0;
        end
      end

      ST_RUN, ST_MEM_WAIT: begin
        if (memwait) begin
          // A branch seen during a wait stays frozen in Execute and flushes once the wait ends.
          StallF     = 1'b1;
          StallD     = 1'b1;
          StallE     = 1'b1;
          StallM     = 1'b1;
          FlushW     = 1'b1;
          state_next = ST_MEM_WAIT;
          if (state_reg == ST_RUN) begin
            wait_cnt_next = WW'(1);
          end else if (wait_cnt_reg != WAIT_MAX) begin
            wait_cnt_next = wait_cnt_reg + 1'b1;
          end
          if (wait_cnt_next == WAIT_MAX) begin
            mem_timeout_next = 1'b1;
          end
        end else begin
          state_next    = ST_RUN;
          wait_cnt_next = '0;
          if (PCSrcE) begin
            FlushD = 1'b1;
            FlushE = 1'b1;
            if (flush_events_reg != CNT_MAX) begin
              flush_events_next = flush_events_reg + 1'b1;
            end
          end else if (load_use) begin
            StallF = 1'b1;
            StallD = 1'b1;
            FlushE = 1'b1;
          end
        end

        if (StallF && (stall_cycles_reg != CNT_MAX)) begin
          stall_cycles_next = stall_cycles_reg + 1'b1;
        end
      end

      default: begin
        state_next = ST_BOOT;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_reg        <= ST_BOOT;
      boot_cnt_reg     <= '0;
      wait_cnt_reg     <= '0;
      mem_timeout_reg  <= 1'b0;
      stall_cycles_reg <= '0;
      flush_events_reg <= '0;
    end else begin
      state_reg        <= state_next;
      boot_cnt_reg     <= boot_cnt_next;
      wait_cnt_reg     <= wait_cnt_next;
      mem_timeout_reg  <= mem_timeout_next;
      stall_cycles_reg <= stall_cycles_next;
      flush_events_reg <= flush_events_next;
    end
  end

  assign state        = state_reg;
  assign mem_timeout  = mem_timeout_reg;
  assign stall_cycles = stall_cycles_reg;
  assign flush_events = flush_events_reg;

endmodule
